// File: rtl/fir_stream_mc_if.sv
// Sample/result streams and coefficient write port of the multi-channel FIR.
// master drives samples, coefficients and out_ready; slave is the filter.
interface fir_stream_mc_if #(
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int NTAPS = 64,
  parameter int NCH   = 2
);
  localparam int AW  = $clog2(NTAPS);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic                  coef_we;
  logic [AW-1:0]         coef_addr;
  logic signed [CW-1:0]  coef_din;
  logic                  coef_ready;

  logic                  in_valid;
  logic                  in_ready;
  logic [CHW-1:0]        in_ch;
  logic signed [DW-1:0]  in_data;

  logic                  out_valid;
  logic                  out_ready;
  logic [CHW-1:0]        out_ch;
  logic signed [DW-1:0]  out_data;

  modport master (
    output coef_we, coef_addr, coef_din, in_valid, in_ch, in_data, out_ready,
    input  coef_ready, in_ready, out_valid, out_ch, out_data
  );

  modport slave (
    input  coef_we, coef_addr, coef_din, in_valid, in_ch, in_data, out_ready,
    output coef_ready, in_ready, out_valid, out_ch, out_data
  );
endinterface

// File: rtl/fir_stream_mc.sv
// Multi-channel streaming FIR with one time-shared MAC; result NTAPS+2 edges after accept.
// Result is held until out_ready; in_ready and coef_ready stay low until that handshake.
module fir_stream_mc #(
  parameter int DW        = 16,
  parameter int CW        = 16,
  parameter int NTAPS     = 64,
  parameter int NCH       = 2,
  parameter int OUT_SHIFT = 15
) (
  input  logic             clk,
  input  logic             rst,
  fir_stream_mc_if.slave   bus,
  output logic             sat_flag
);
  localparam int AW   = $clog2(NTAPS);
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int NCHP = 1 << CHW;
  localparam int PW   = DW + CW;
  localparam int ACCW = DW + CW + AW;

  localparam logic signed [ACCW-1:0] RND_C = ACCW'(1) << (OUT_SHIFT - 1);
  localparam logic signed [ACCW-1:0] MAXV  = (ACCW'(1) << (DW - 1)) - ACCW'(1);
  localparam logic signed [ACCW-1:0] MINV  = -(ACCW'(1) << (DW - 1));

  typedef enum logic [2:0] {IDLE, MAC, ACC, RND, OUT} state_t;
  state_t state, state_n;

  logic [AW-1:0]         wp [NCHP];
  logic [AW:0]           fc [NCHP];
  logic signed [DW-1:0]  smp_mem [NCHP*NTAPS];
  logic signed [CW-1:0]  coef_mem [NTAPS];

  logic [AW-1:0]         k;
  logic [CHW-1:0]        ch_q;
  logic [AW-1:0]         wp_cur;
  logic [AW:0]           fc_cur;
  logic signed [DW-1:0]  smp_q;
  logic signed [CW-1:0]  coef_q;
  logic                  tap_ok_q;
  logic                  prod_vld;
  logic signed [ACCW-1:0] acc;

  logic                  accept;
  logic [AW-1:0]         wp_new;
  logic [AW:0]           fc_sel;
  logic [AW:0]           fc_new;
  logic [AW-1:0]         rd_idx;
  logic signed [PW-1:0]  prod;
  logic signed [ACCW-1:0] rnd;
  logic signed [ACCW-1:0] shf;
  logic signed [DW-1:0]  sat_val;
  logic                  sat_hit;

  assign bus.in_ready   = (state == IDLE);
  assign bus.coef_ready = (state == IDLE);
  assign bus.out_valid  = (state == OUT);

  // Out-of-range channels are never accepted but do not stall the source.
  assign accept = (state == IDLE) && bus.in_valid && (int'(bus.in_ch) < NCH);
  assign wp_new = wp[bus.in_ch] + AW'(1);
  assign fc_sel = fc[bus.in_ch];
  assign fc_new = (fc_sel == (AW+1)'(NTAPS)) ? fc_sel : fc_sel + (AW+1)'(1);
  assign rd_idx = wp_cur - k;
  assign prod   = tap_ok_q ? PW'(smp_q) * PW'(coef_q) : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = MAC;
      MAC:     if (k == AW'(NTAPS - 1)) state_n = ACC;
      ACC:     state_n = RND;
      RND:     state_n = OUT;
      OUT:     if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    rnd     = acc + RND_C;
    shf     = rnd >>> OUT_SHIFT;
    sat_val = shf[DW-1:0];
    sat_hit = 1'b0;
    if (shf > MAXV) begin
      sat_val = MAXV[DW-1:0];
      sat_hit = 1'b1;
    end else if (shf < MINV) begin
      sat_val = MINV[DW-1:0];
      sat_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k            <= '0;
      ch_q         <= '0;
      wp_cur       <= '0;
      fc_cur       <= '0;
      acc          <= '0;
      prod_vld     <= 1'b0;
      bus.out_data <= '0;
      bus.out_ch   <= '0;
      sat_flag     <= 1'b0;
      for (int i = 0; i < NCHP; i++) begin
        wp[i] <= '0;
        fc[i] <= '0;
      end
    end else begin
      prod_vld <= (state == MAC);
      if (accept) begin
        wp[bus.in_ch] <= wp_new;
        fc[bus.in_ch] <= fc_new;
        ch_q          <= bus.in_ch;
        wp_cur        <= wp_new;
        fc_cur        <= fc_new;
        acc           <= '0;
        k             <= '0;
      end
      if (state == MAC) k <= k + AW'(1);
      if (prod_vld) acc <= acc + ACCW'(prod);
      if (state == RND) begin
        bus.out_data <= sat_val;
        bus.out_ch   <= ch_q;
        if (sat_hit) sat_flag <= 1'b1;
      end
    end
  end

  // History beyond the fill count reads as zero, so the sample RAM never needs clearing.
  always_ff @(posedge clk) begin
    if (accept) smp_mem[{bus.in_ch, wp_new}] <= bus.in_data;
    if (bus.coef_we && (state == IDLE)) coef_mem[bus.coef_addr] <= bus.coef_din;
    smp_q    <= smp_mem[{ch_q, rd_idx}];
    coef_q   <= coef_mem[k];
    tap_ok_q <= ({1'b0, k} < fc_cur);
  end
endmodule
